// File: rtl/gb_alu_serial.sv
// Slice-serial SM83-style ALU: SLICE_WIDTH bits per clock, LSB first, valid/ready on both sides.
// Define GB_ALU_FAST_EN to compute the full width in a single BUSY cycle.
module gb_alu_serial #(
    parameter int DATA_WIDTH  = 8,
    parameter int SLICE_WIDTH = 4,
    parameter int HALF_BIT    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_A,
    input  logic [DATA_WIDTH-1:0] operand_B,
    input  logic                  carry_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic [3:0]            flags
);

    localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
    localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int H_SLICE    = HALF_BIT / SLICE_WIDTH;

`ifdef GB_ALU_FAST_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;

    if (SLICE_WIDTH <= 0 || DATA_WIDTH <= 0 || (DATA_WIDTH % SLICE_WIDTH) != 0 ||
        ((HALF_BIT + 1) % SLICE_WIDTH) != 0 || HALF_BIT >= DATA_WIDTH) begin : g_bad_params
        $error("gb_alu_serial: illegal DATA_WIDTH/SLICE_WIDTH/HALF_BIT combination");
    end

    logic [1:0]            state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic                  carry_q, carry_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  zacc_q, zacc_d;
    logic                  h_q, h_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [3:0]            flags_q, flags_d;

    logic [SLICE_WIDTH-1:0] sa, sb;
    logic [SLICE_WIDTH:0]   ext;
    logic                   c, hc, zacc, last, accept;
    logic [DATA_WIDTH-1:0]  res;

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE && out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign flags     = flags_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        zacc_d   = zacc_q;
        h_d      = h_q;
        result_d = result_q;
        flags_d  = flags_q;

        sa   = '0;
        sb   = '0;
        ext  = '0;
        c    = carry_q;
        hc   = h_q;
        zacc = zacc_q;
        res  = result_q;
        last = 1'b0;

        // Serial mode evaluates only slice cnt_q; fast mode chains every slice in one cycle.
        for (int i = 0; i < NUM_SLICES; i++) begin
            if (FAST_EN || i == int'(cnt_q)) begin
                sa = a_q[i*SLICE_WIDTH +: SLICE_WIDTH];
                sb = b_q[i*SLICE_WIDTH +: SLICE_WIDTH];
                case (op_q)
                    OP_ADD, OP_ADC:
                        ext = {1'b0, sa} + {1'b0, sb} + {{SLICE_WIDTH{1'b0}}, c};
                    OP_SUB, OP_SBC, OP_CP:
                        ext = {1'b0, sa} - {1'b0, sb} - {{SLICE_WIDTH{1'b0}}, c};
                    OP_AND:  ext = {1'b0, sa & sb};
                    OP_XOR:  ext = {1'b0, sa ^ sb};
                    default: ext = {1'b0, sa | sb};
                endcase
                c = ext[SLICE_WIDTH];
                res[i*SLICE_WIDTH +: SLICE_WIDTH] = (op_q == OP_CP) ? sa : ext[SLICE_WIDTH-1:0];
                zacc = zacc | (|ext[SLICE_WIDTH-1:0]);
                if (i == H_SLICE) hc = c;
                if (i == NUM_SLICES - 1) last = 1'b1;
            end
        end

        case (state_q)
            ST_BUSY: begin
                carry_d  = c;
                h_d      = hc;
                zacc_d   = zacc;
                result_d = res;
                cnt_d    = cnt_q + 1'b1;
                if (last) begin
                    state_d = ST_DONE;
                    case (op_q)
                        OP_ADD, OP_ADC:        flags_d = {~zacc, 1'b0, hc, c};
                        OP_SUB, OP_SBC, OP_CP: flags_d = {~zacc, 1'b1, hc, c};
                        OP_AND:                flags_d = {~zacc, 1'b0, 1'b1, 1'b0};
                        default:               flags_d = {~zacc, 1'b0, 1'b0, 1'b0};
                    endcase
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            state_d = ST_BUSY;
            op_d    = op;
            a_d     = operand_A;
            b_d     = operand_B;
            carry_d = (op == OP_ADC || op == OP_SBC) ? carry_in : 1'b0;
            cnt_d   = '0;
            zacc_d  = 1'b0;
            h_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            zacc_q   <= 1'b0;
            h_q      <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            zacc_q   <= zacc_d;
            h_q      <= h_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

endmodule
